// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Purpose  : Synchronous front-end controller for a 256x8 asynchronous SRAM.
//            Accepts single-beat read/write requests on a valid/ready
//            handshake. Generates cs/wr/rd strobes with one cycle of setup and
//            one cycle of hold around a WAIT-cycle write pulse or a
//            (WAIT+1)-cycle read access. Read data is returned on a one-cycle
//            response strobe.
// Params   : WAIT                - strobe width in clock cycles, 1..15
// Macro    : SRAM_CTRL_VERIFY_EN - when defined, every write is followed by a
//            read-back of the same address. A mismatch sets the sticky err
//            flag. When undefined, err is tied to 0.
// Ports    : clk, rst_n (async active-low)
//            req_valid/req_ready/req_we/req_addr/req_wdata - request channel
//            rsp_valid/rsp_rdata                           - read response
//            err                                           - sticky verify error
//            sram_cs/sram_wr/sram_rd(active-low)/sram_addr/sram_din/sram_dout
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
    parameter int unsigned WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       err,
    output logic       sram_cs,
    output logic       sram_wr,
    output logic       sram_rd,
    output logic [7:0] sram_addr,
    output logic [7:0] sram_din,
    input  logic [7:0] sram_dout
);

    // Counter reload values: the pulse/access state is left when the count hits 0.
    localparam logic [3:0] C_CNT_PULSE  = 4'(WAIT - 1);
    localparam logic [3:0] C_CNT_ACCESS = 4'(WAIT);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WSETUP  = 4'd1,
        S_WPULSE  = 4'd2,
        S_WHOLD   = 4'd3,
        S_RSETUP  = 4'd4,
        S_RACCESS = 4'd5,
        S_RHOLD   = 4'd6
`ifdef SRAM_CTRL_VERIFY_EN
        ,
        S_VSETUP  = 4'd7,
        S_VACCESS = 4'd8,
        S_VHOLD   = 4'd9
`endif
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_accept;
    logic       w_capture;
    logic       w_vcheck;
    logic       w_cs_nxt;
    logic       w_wr_nxt;
    logic       w_rd_nxt;

    logic       r_cs;
    logic       r_wr;
    logic       r_rd;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;

    // ------------------------------------------------------------------
    // Next-state logic. Strobes are decoded from the NEXT state and then
    // registered, so cs/wr/rd come straight from flops and cannot glitch
    // toward the asynchronous SRAM.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_vcheck    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = req_we ? S_WSETUP : S_RSETUP;
                end
            end
            S_WSETUP: begin
                w_state_nxt = S_WPULSE;
                w_cnt_nxt   = C_CNT_PULSE;
            end
            S_WPULSE: begin
                if (r_cnt == 4'd0) w_state_nxt = S_WHOLD;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            S_WHOLD: begin
`ifdef SRAM_CTRL_VERIFY_EN
                w_state_nxt = S_VSETUP;
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_RSETUP: begin
                w_state_nxt = S_RACCESS;
                w_cnt_nxt   = C_CNT_ACCESS;
            end
            S_RACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RHOLD;
                    w_capture   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            S_RHOLD: begin
                w_state_nxt = S_IDLE;
            end
`ifdef SRAM_CTRL_VERIFY_EN
            S_VSETUP: begin
                w_state_nxt = S_VACCESS;
                w_cnt_nxt   = C_CNT_ACCESS;
            end
            S_VACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_VHOLD;
                    w_vcheck    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            S_VHOLD: begin
                w_state_nxt = S_IDLE;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_cs_nxt = (w_state_nxt != S_IDLE);
        w_wr_nxt = (w_state_nxt == S_WPULSE);
`ifdef SRAM_CTRL_VERIFY_EN
        w_rd_nxt = !((w_state_nxt == S_RACCESS) || (w_state_nxt == S_VACCESS));
`else
        w_rd_nxt = !(w_state_nxt == S_RACCESS);
`endif
    end

    // ------------------------------------------------------------------
    // State, strobe and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_cs    <= 1'b0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b1;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cs    <= w_cs_nxt;
            r_wr    <= w_wr_nxt;
            r_rd    <= w_rd_nxt;
            // Address and write data move only on the accept edge, so they
            // stay stable through setup, strobe and hold.
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_capture) begin
                r_rdata <= sram_dout;
            end
        end
    end

`ifdef SRAM_CTRL_VERIFY_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_vcheck && (sram_dout != r_wdata)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RHOLD);
    assign rsp_rdata = r_rdata;
    assign sram_cs   = r_cs;
    assign sram_wr   = r_wr;
    assign sram_rd   = r_rd;
    assign sram_addr = r_addr;
    assign sram_din  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_ctrl
// Purpose  : Self-checking bench for sram_ctrl. Two instances (WAIT=1 and
//            WAIT=3) each drive their own behavioural SRAM. A transaction-level
//            model predicts every output from the cycle offset since accept,
//            and it is compared on every falling edge. Directed scenarios add
//            hand-computed literal expectations.
// Macro    : SRAM_CTRL_VERIFY_EN - must match the RTL build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

`ifdef SRAM_CTRL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic       req_valid [2];
    logic       req_we    [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       corrupt   [2];
    logic       req_ready [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_rdata [2];
    logic       err       [2];
    logic       sram_cs   [2];
    logic       sram_wr   [2];
    logic       sram_rd   [2];
    logic [7:0] sram_addr [2];
    logic [7:0] sram_din  [2];
    logic [7:0] sram_dout [2];

    int         wr_rises     [2];
    logic [7:0] last_wr_addr [2];
    int         wr_run       [2];
    int         rd_run       [2];

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s [inst %0d] t=%0t: got 0x%0h, expected 0x%0h",
                     name, k, $time, act, want);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int W     = (k == 0) ? 1 : 3;
        localparam int OCC_W = VERIFY ? (2 * W + 5) : (W + 2);
        localparam int OCC_R = W + 3;

        sram_ctrl #(.WAIT(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[k]),
            .req_ready (req_ready[k]),
            .req_we    (req_we[k]),
            .req_addr  (req_addr[k]),
            .req_wdata (req_wdata[k]),
            .rsp_valid (rsp_valid[k]),
            .rsp_rdata (rsp_rdata[k]),
            .err       (err[k]),
            .sram_cs   (sram_cs[k]),
            .sram_wr   (sram_wr[k]),
            .sram_rd   (sram_rd[k]),
            .sram_addr (sram_addr[k]),
            .sram_din  (sram_din[k]),
            .sram_dout (sram_dout[k])
        );

        // Behavioural SRAM: commits on rising wr, drives dout while cs & !rd.
        logic [7:0] dev_mem [256];
        // Reference copy of memory contents held by the model.
        logic [7:0] exp_mem [256];
        initial begin
            for (int a = 0; a < 256; a++) begin
                dev_mem[a] = 8'(a) ^ 8'h5A;
                exp_mem[a] = 8'(a) ^ 8'h5A;
            end
        end

        assign sram_dout[k] = (sram_cs[k] && !sram_rd[k])
                              ? (corrupt[k] ? 8'h00 : dev_mem[sram_addr[k]]) : 8'h00;

        always @(posedge sram_wr[k]) begin
            if (sram_cs[k]) dev_mem[sram_addr[k]] = sram_din[k];
            wr_rises[k]++;
            last_wr_addr[k] = sram_addr[k];
            chk("cs_at_wr_rise", k, 32'(sram_cs[k]), 32'd1);
        end

        // Strobe width monitors: length of the most recent complete run.
        int wr_cur = 0;
        int rd_cur = 0;
        always @(negedge clk) begin
            if (sram_wr[k]) wr_cur++;
            else if (wr_cur != 0) begin wr_run[k] = wr_cur; wr_cur = 0; end
            if (!sram_rd[k]) rd_cur++;
            else if (rd_cur != 0) begin rd_run[k] = rd_cur; rd_cur = 0; end
        end

        // Transaction model: n is 1 during the cycle after the accept edge,
        // increments each edge, and returns to 0 once occupancy is over.
        int         n       = 0;
        logic       m_we    = 1'b0;
        logic       m_bad   = 1'b0;
        logic [7:0] e_addr  = 8'h00;
        logic [7:0] e_din   = 8'h00;
        logic [7:0] e_rdata = 8'h00;
        logic       e_err   = 1'b0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                n = 0; e_addr = 8'h00; e_din = 8'h00; e_rdata = 8'h00; e_err = 1'b0;
            end else if (n == 0) begin
                if (req_valid[k]) begin
                    n      = 1;
                    m_we   = req_we[k];
                    e_addr = req_addr[k];
                    e_din  = req_wdata[k];
                    m_bad  = corrupt[k];
                end
            end else begin
                n++;
                if (m_we && n == 2) exp_mem[e_addr] = e_din;
                if (!m_we && n == W + 3) e_rdata = exp_mem[e_addr];
                if (VERIFY && m_we && n == 2 * W + 5 && m_bad && e_din != 8'h00) e_err = 1'b1;
                if (n > (m_we ? OCC_W : OCC_R)) n = 0;
            end
        end

        // Cycle-by-cycle comparison against the model.
        always @(negedge clk) begin
            logic busy, e_wr, e_rdlow;
            busy    = (n != 0);
            e_wr    = m_we && n >= 2 && n <= W + 1;
            e_rdlow = (!m_we && n >= 2 && n <= W + 2) ||
                      (VERIFY && m_we && n >= W + 4 && n <= 2 * W + 4);
            chk("req_ready", k, 32'(req_ready[k]), 32'(!busy));
            chk("sram_cs",   k, 32'(sram_cs[k]),   32'(busy));
            chk("sram_wr",   k, 32'(sram_wr[k]),   32'(e_wr));
            chk("sram_rd",   k, 32'(sram_rd[k]),   32'(!e_rdlow));
            chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(!m_we && n == W + 3));
            chk("sram_addr", k, 32'(sram_addr[k]), 32'(e_addr));
            chk("sram_din",  k, 32'(sram_din[k]),  32'(e_din));
            chk("rsp_rdata", k, 32'(rsp_rdata[k]), 32'(e_rdata));
            chk("err",       k, 32'(err[k]),       32'(e_err));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic garble(input int k);
        req_addr[k]  = 8'($urandom);
        req_we[k]    = 1'($urandom);
        req_wdata[k] = 8'($urandom);
    endtask

    // Present a request and return 1 time unit after its accept edge.
    task automatic issue(input int k, input logic we, input logic [7:0] a,
                         input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = d;
        for (int i = 0; i < 64; i++) begin
            if (req_ready[k]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", k, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
    endtask

    // Count busy cycles until ready returns, toggling idle payload meanwhile.
    task automatic busy_count(input int k, output int occ);
        bit ok;
        ok  = 1'b0;
        occ = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_ready[k]) begin ok = 1'b1; break; end
            occ++;
            garble(k);
        end
        if (!ok) chk("idle_timeout", k, 32'd0, 32'd1);
    endtask

    task automatic do_write(input int k, input logic [7:0] a, input logic [7:0] d,
                            output int occ);
        issue(k, 1'b1, a, d);
        busy_count(k, occ);
    endtask

    task automatic do_read(input int k, input logic [7:0] a, output logic [7:0] d,
                           output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        d   = 8'h00;
        issue(k, 1'b0, a, 8'h00);
        for (int i = 1; i < 64; i++) begin
            @(negedge clk);
            if (rsp_valid[k] && lat == 0) begin lat = i; d = rsp_rdata[k]; end
            if (req_ready[k]) begin ok = 1'b1; break; end
            garble(k);
        end
        if (!ok) chk("read_timeout", k, 32'd0, 32'd1);
    endtask

    task automatic run_suite(input int k);
        logic [7:0] d;
        int lat, occ, r0;
        int exp_wocc;
        exp_wocc = VERIFY ? ((k == 0) ? 7 : 11) : ((k == 0) ? 3 : 5);

        // Single write then read-back.
        r0 = wr_rises[k];
        do_write(k, 8'h3C, 8'hA5, occ);
        chk("wr_rise_count",   k, 32'(wr_rises[k] - r0), 32'd1);
        chk("wr_rise_addr",    k, 32'(last_wr_addr[k]), 32'h3C);
        chk("write_occupancy", k, 32'(occ), 32'(exp_wocc));
        do_read(k, 8'h3C, d, lat);
        chk("read_data_3c",    k, 32'(d), 32'hA5);
        chk("read_latency",    k, 32'(lat), (k == 0) ? 32'd4 : 32'd6);
        chk("wr_width",        k, 32'(wr_run[k]), (k == 0) ? 32'd1 : 32'd3);
        chk("rd_width",        k, 32'(rd_run[k]), (k == 0) ? 32'd2 : 32'd4);

        // Back-to-back writes with req_valid held high.
        req_valid[k] = 1'b1; req_we[k] = 1'b1; req_addr[k] = 8'h00; req_wdata[k] = 8'h11;
        for (int i = 0; i < 64 && !req_ready[k]; i++) @(negedge clk);
        @(posedge clk);
        #1;
        req_addr[k] = 8'hFF; req_wdata[k] = 8'hEE;
        occ = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_ready[k]) break;
            occ++;
        end
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        chk("b2b_ready_low", k, 32'(occ), 32'(exp_wocc));
        busy_count(k, occ);
        do_read(k, 8'h00, d, lat);
        chk("read_data_00", k, 32'(d), 32'h11);
        do_read(k, 8'hFF, d, lat);
        chk("read_data_ff", k, 32'(d), 32'hEE);

        // Corrupted read-back during verify; err must stick through good writes.
        corrupt[k] = 1'b1;
        do_write(k, 8'h40, 8'h5A, occ);
        corrupt[k] = 1'b0;
        chk("err_after_bad", k, 32'(err[k]), 32'(VERIFY));
        do_write(k, 8'h41, 8'h33, occ);
        chk("err_sticky", k, 32'(err[k]), 32'(VERIFY));

        // Reset during WSETUP of a write: strobes drop at once, no commit.
        r0 = wr_rises[k];
        issue(k, 1'b1, 8'h10, 8'h77);
        chk("abort_in_setup_cs", k, 32'(sram_cs[k]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_cs", k, 32'(sram_cs[k]), 32'd0);
        chk("abort_wr", k, 32'(sram_wr[k]), 32'd0);
        chk("abort_rd", k, 32'(sram_rd[k]), 32'd1);
        chk("abort_err", k, 32'(err[k]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_no_wr_rise", k, 32'(wr_rises[k] - r0), 32'd0);
        do_read(k, 8'h10, d, lat);
        chk("read_after_abort", k, 32'(d), 32'h4A);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b1;   // must be ignored while in reset
            req_we[k]    = 1'b1;
            req_addr[k]  = 8'h99;
            req_wdata[k] = 8'h66;
            corrupt[k]   = 1'b0;
            wr_rises[k]  = 0;
            wr_run[k]    = 0;
            rd_run[k]    = 0;
            last_wr_addr[k] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", k, 32'(req_ready[k]), 32'd1);
            chk("rst_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
            chk("rst_rsp_rdata", k, 32'(rsp_rdata[k]), 32'h00);
            chk("rst_err",       k, 32'(err[k]),       32'd0);
            chk("rst_cs",        k, 32'(sram_cs[k]),   32'd0);
            chk("rst_wr",        k, 32'(sram_wr[k]),   32'd0);
            chk("rst_rd",        k, 32'(sram_rd[k]),   32'd1);
            chk("rst_addr",      k, 32'(sram_addr[k]), 32'h00);
            chk("rst_din",       k, 32'(sram_din[k]),  32'h00);
            req_valid[k] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_suite(0);
        run_suite(1);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
                 n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
# sram_ctrl

Synchronous front-end controller for the 256x8 asynchronous SRAM macro (`sram`). It accepts single-beat read and write requests over a valid/ready handshake on the system clock. It generates the SRAM strobes with guaranteed setup and hold:
- `cs`: active-high chip select.
- `wr`: the write is committed on the rising edge.
- `rd`: active-low; data is latched on the falling edge and driven while low.

Read data is returned on a one-cycle response strobe. It sits directly upstream of `sram` and drives all of its inputs.

## Interface
- `WAIT`, default 1: strobe width in clock cycles; legal range 1..15.
- `clk  in  1`: clock; all state changes on the rising edge.
- `rst_n  in  1`: asynchronous active-low reset.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: controller idle; the request is accepted on an edge where `req_valid && req_ready`.
- `req_we  in  1`: 1 = write, 0 = read.
- `req_addr  in  8`: SRAM address.
- `req_wdata  in  8`: write data.
- `rsp_valid  out  1`: one-cycle pulse; read data is valid.
- `rsp_rdata  out  8`: last read data; held until the next read completes.
- `err  out  1`: sticky verify-mismatch flag; tied to 0 when verify is compiled out.
- `sram_cs  out  1`: to SRAM `cs`.
- `sram_wr  out  1`: to SRAM `wr`.
- `sram_rd  out  1`: to SRAM `rd`, active-low.
- `sram_addr  out  8`: to SRAM `addr`.
- `sram_din  out  8`: to SRAM `din`.
- `sram_dout  in  8`: from SRAM `dout`; meaningful only while `cs=1` and `rd=0`.

## Operation
States and SRAM outputs:
- **IDLE**: `req_ready=1`, `cs=0`, `wr=0`, `rd=1`.
  - On accept, register `addr`/`wdata`/`we`, drive `sram_addr`/`sram_din`, then go to WSETUP or RSETUP.
- **WSETUP** (1 cycle): `cs=1`, `wr=0`, `rd=1`; address and data are stable.
- **WPULSE** (`WAIT` cycles): `cs=1`, `wr=1`. The SRAM commits on the rising `wr`.
- **WHOLD** (1 cycle): `cs=1`, `wr=0`; address and data are still held. Next state is IDLE, or VSETUP when verify is enabled.
- **RSETUP** (1 cycle): `cs=1`, `rd=1`.
- **RACCESS** (`WAIT+1` cycles): `cs=1`, `rd=0`. The SRAM latches on the falling `rd`.
  - `sram_dout` is captured into `rsp_rdata` on the edge that leaves RACCESS.
- **RHOLD** (1 cycle): `cs=1`, `rd=1`, `rsp_valid=1`. Next state is IDLE.

General rules:
- `req_ready` is high only in IDLE. Requests arriving while busy are stalled; the requester must hold `req_valid` and all payload stable until accepted.
- `wr` and `rd` are never both active. `cs` is 0 only in IDLE.
- `sram_addr`/`sram_din` change only on the accept edge.
- A single counter (4 bits, loaded with `WAIT-1` or `WAIT`) times WPULSE and RACCESS.

## Timing
- Accept on edge E:
  - Write: occupancy is `WAIT+2` cycles. `req_ready` returns at edge `E+WAIT+2`; the earliest next accept is that edge.
  - Read: `rsp_valid` is high during the cycle after edge `E+WAIT+2`. `req_ready` returns at edge `E+WAIT+3`.
- With `WAIT=1`: a write takes 3 busy cycles and a read takes 4.
- Back-to-back requests: there is no bubble beyond the IDLE cycle in which the accept occurs.
- Reset values:
  - `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0x00`, `err=0`.
  - `sram_cs=0`, `sram_wr=0`, `sram_rd=1`, `sram_addr=0x00`, `sram_din=0x00`.
  - State is IDLE.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronously).
  - An in-flight write aborted before WPULSE never produces a rising `wr`.
  - An aborted read produces no `rsp_valid`.
- `req_valid` asserted during reset is ignored. The first accept is possible on the first edge after `rst_n` rises.

## Configuration
- Macro: `SRAM_CTRL_VERIFY_EN`.
- **Defined**: every write is followed by a read-back of the same address.
  - Read-back sequence: VSETUP (1 cycle, as RSETUP), then VACCESS (`WAIT+1` cycles, as RACCESS), then VHOLD (1 cycle, `rd=1`).
  - The captured byte is compared with the registered `wdata`. On mismatch, `err` is set; it stays set until `rst_n` is asserted.
  - Verify reads do not assert `rsp_valid` and do not modify `rsp_rdata`.
  - Write occupancy becomes `2*WAIT+5` cycles.
- **Undefined**: there are no verify states, `err` is constant 0, and write occupancy is `WAIT+2`.

## Test plan
- Write 0xA5 to 0x3C, then read 0x3C (`WAIT=1`):
  - `wr` rises exactly once while `cs=1` and `addr=0x3C`.
  - `rsp_valid` pulses for one cycle, 3 cycles after the read accept edge, with `rsp_rdata=0xA5`.
- Write 0x11 to 0x00 and 0xEE to 0xFF back-to-back with `req_valid` held high:
  - `req_ready` is low for 3 cycles between accepts.
  - Reading 0x00 then 0xFF returns 0x11, then 0xEE.
- `WAIT=3`:
  - `wr` is high for exactly 3 cycles and `rd` is low for exactly 4 cycles.
  - Write occupancy is 5 cycles; the read response arrives 5 cycles after accept.
- Assert `rst_n=0` during WSETUP of a write of 0x77 to 0x10:
  - `cs=0`, `wr=0`, `rd=1` immediately.
  - A later read of 0x10 returns the prior contents, not 0x77.
- With `SRAM_CTRL_VERIFY_EN`, the bench forces `sram_dout=0x00` during verify of a write of 0x5A:
  - `err` goes to 1 and stays 1 through later good writes.
  - There is no `rsp_valid` during verify.
  - Without the macro, `err` stays 0.
- While the controller is busy, toggle `req_addr`/`req_we` with `req_valid=0`:
  - `sram_addr` and the strobe sequence are unaffected.
  - `rsp_rdata` is unchanged until the next read's RHOLD.
